axi_burst_manager: RTL and testbench

AXI4 manager supporting INCR bursts, generalising the single-beat AXI-lite manager. It accepts burst write/read commands from a local client (CPU model or bench), issues AW/W/B and AR/R traffic with correct AxLEN/WLAST sequencing, and returns per-burst write status and per-beat read data. Write and read engines are independent and may run concurrently. It sits between the client and the AXI4 interconnect/subordinate.

---
 rtl/axi_helper.sv | 58 +++++
 rtl/beat_counter.sv | 30 +++
 rtl/axi_burst_manager.sv | 273 +++++++++++++++++++++++++++
 tb/tb_axi_burst_manager.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_helper.sv
// axi_helper: shared AXI4 types and helpers for the burst manager slice.
//   resp_t      - AXI xRESP encodings
//   burst_t     - AxBURST encodings (FIXED/INCR/WRAP)
//   wr_state_t  - write engine states
//   rd_state_t  - read engine states
//   axsize()    - AxSIZE for a given data width
//   cmd_illegal - length / 4 KB page-crossing legality check for a burst
package axi_helper;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_t;

    // R_ERR emits the single DECERR beat for a rejected read command.
    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_ERR
    } rd_state_t;

    function automatic logic [2:0] axsize(input int unsigned data_w);
        return 3'($clog2(data_w / 8));
    endfunction

    // page_off is the aligned start address within its 4 KB page. The burst
    // is legal when its last byte still lies inside the same page, so the
    // end offset may equal 4096 exactly.
    function automatic logic cmd_illegal(input logic [11:0]   page_off,
                                         input logic [7:0]    len,
                                         input logic [2:0]    size,
                                         input int unsigned   max_beats);
        logic [16:0] beats;
        logic [16:0] span_end;
        beats    = {9'd0, len} + 17'd1;
        span_end = {5'd0, page_off} + (beats << size);
        return (32'(beats) > max_beats) || (span_end > 17'h1000);
    endfunction

endpackage

// File: rtl/beat_counter.sv
// beat_counter: per-burst beat counter.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - restart counting at zero (command accept)
//   incr       - one beat transferred
//   len        - burst length minus one
//   last       - current beat is the final beat of the burst
module beat_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       incr,
    input  logic [7:0] len,
    output logic       last
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 8'd1;
        end
    end

    assign last = (count == len);

endmodule

// File: rtl/axi_burst_manager.sv
// axi_burst_manager: AXI4 INCR burst manager with independent write and read
// engines driven by a simple local command/data interface.
//   ACLK, ARESETn                      - clock, asynchronous active-low reset
//   wr_req_*, wr_addr, wr_len          - write burst command (len = beats-1)
//   wr_data_*, wr_data                 - write beat stream (passes to W)
//   wr_done, wr_resp                   - one-cycle completion pulse + BRESP
//   rd_req_*, rd_addr, rd_len          - read burst command
//   rd_valid/ready, rd_data/resp/last  - read beat stream (passes from R)
//   AW*/W*/B*/AR*/R*                   - AXI4 manager interface
// Commands that exceed MAX_BEATS or cross a 4 KB page are accepted but
// answered locally with DECERR and never reach the bus.
module axi_burst_manager
    import axi_helper::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic                wr_req_valid,
    output logic                wr_req_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [7:0]          wr_len,
    input  logic                wr_data_valid,
    output logic                wr_data_ready,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_done,
    output logic [1:0]          wr_resp,

    input  logic                rd_req_valid,
    output logic                rd_req_ready,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [7:0]          rd_len,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic [1:0]          rd_resp,
    output logic                rd_last,

    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,

    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,

    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,

    output logic [ADDR_W-1:0]   ARADDR,
    output logic [7:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,

    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY
);

    localparam int unsigned        STRB_W     = DATA_W / 8;
    localparam logic [2:0]         AXSIZE     = axsize(DATA_W);
    localparam logic [ADDR_W-1:0]  ALIGN_MASK = ~ADDR_W'(STRB_W - 1);

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wr_state_t          wr_state, wr_next;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [7:0]         wr_len_q;
    logic [ADDR_W-1:0]  wr_addr_al;
    logic               wr_illegal;
    logic               wr_accept;
    logic               w_hs;
    logic               wr_last_beat;

    assign wr_addr_al = wr_addr & ALIGN_MASK;
    assign wr_illegal = cmd_illegal(wr_addr_al[11:0], wr_len, AXSIZE, MAX_BEATS);
    assign wr_accept  = (wr_state == W_IDLE) && wr_req_valid;
    assign w_hs       = (wr_state == W_DATA) && wr_data_valid && WREADY;

    beat_counter u_wr_cnt (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .clear (wr_accept),
        .incr  (w_hs),
        .len   (wr_len_q),
        .last  (wr_last_beat)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state  <= W_IDLE;
            wr_addr_q <= '0;
            wr_len_q  <= '0;
            wr_done   <= 1'b0;
            wr_resp   <= '0;
        end else begin
            wr_state <= wr_next;
            wr_done  <= 1'b0;
            if (wr_accept) begin
                wr_addr_q <= wr_addr_al;
                wr_len_q  <= wr_len;
                // Rejected commands complete locally; the engine stays idle.
                if (wr_illegal) begin
                    wr_done <= 1'b1;
                    wr_resp <= DECERR;
                end
            end
            if ((wr_state == W_RESP) && BVALID) begin
                wr_done <= 1'b1;
                wr_resp <= BRESP;
            end
        end
    end

    always_comb begin
        wr_next       = wr_state;
        wr_req_ready  = 1'b0;
        AWVALID       = 1'b0;
        WVALID        = 1'b0;
        WLAST         = 1'b0;
        wr_data_ready = 1'b0;
        BREADY        = 1'b0;
        case (wr_state)
            W_IDLE: begin
                wr_req_ready = 1'b1;
                if (wr_req_valid && !wr_illegal) begin
                    wr_next = W_ADDR;
                end
            end
            W_ADDR: begin
                AWVALID = 1'b1;
                if (AWREADY) begin
                    wr_next = W_DATA;
                end
            end
            W_DATA: begin
                WVALID        = wr_data_valid;
                wr_data_ready = WREADY;
                WLAST         = wr_last_beat;
                if (w_hs && wr_last_beat) begin
                    wr_next = W_RESP;
                end
            end
            W_RESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    wr_next = W_IDLE;
                end
            end
            default: wr_next = W_IDLE;
        endcase
    end

    assign AWADDR  = wr_addr_q;
    assign AWLEN   = wr_len_q;
    assign AWSIZE  = AXSIZE;
    assign AWBURST = BURST_INCR;
    assign WDATA   = wr_data;
    assign WSTRB   = '1;

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rd_state_t          rd_state, rd_next;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic [7:0]         rd_len_q;
    logic [ADDR_W-1:0]  rd_addr_al;
    logic               rd_illegal;
    logic               rd_accept;
    logic               r_hs;
    logic               rd_last_beat;
    logic               rd_err_q;
    logic               r_mismatch;

    assign rd_addr_al = rd_addr & ALIGN_MASK;
    assign rd_illegal = cmd_illegal(rd_addr_al[11:0], rd_len, AXSIZE, MAX_BEATS);
    assign rd_accept  = (rd_state == R_IDLE) && rd_req_valid;
    assign r_hs       = (rd_state == R_DATA) && RVALID && rd_ready;
    // Subordinate's RLAST disagrees with our own beat count.
    assign r_mismatch = (RLAST != rd_last_beat);

    beat_counter u_rd_cnt (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .clear (rd_accept),
        .incr  (r_hs),
        .len   (rd_len_q),
        .last  (rd_last_beat)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state  <= R_IDLE;
            rd_addr_q <= '0;
            rd_len_q  <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            rd_state <= rd_next;
            if (rd_accept) begin
                rd_addr_q <= rd_addr_al;
                rd_len_q  <= rd_len;
                rd_err_q  <= 1'b0;
            end else if (r_hs && r_mismatch) begin
                rd_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_next      = rd_state;
        rd_req_ready = 1'b0;
        ARVALID      = 1'b0;
        RREADY       = 1'b0;
        rd_valid     = 1'b0;
        rd_data      = '0;
        rd_resp      = RESP_OKAY;
        rd_last      = 1'b0;
        case (rd_state)
            R_IDLE: begin
                rd_req_ready = 1'b1;
                if (rd_req_valid) begin
                    rd_next = rd_illegal ? R_ERR : R_ADDR;
                end
            end
            R_ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    rd_next = R_DATA;
                end
            end
            R_DATA: begin
                rd_valid = RVALID;
                RREADY   = rd_ready;
                rd_data  = RDATA;
                rd_last  = RLAST;
                // Error flag covers the offending beat itself and any after it.
                rd_resp  = (rd_err_q || r_mismatch) ? RESP_SLVERR : RRESP;
                if (r_hs && RLAST) begin
                    rd_next = R_IDLE;
                end
            end
            R_ERR: begin
                rd_valid = 1'b1;
                rd_last  = 1'b1;
                rd_resp  = DECERR;
                if (rd_ready) begin
                    rd_next = R_IDLE;
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    assign ARADDR  = rd_addr_q;
    assign ARLEN   = rd_len_q;
    assign ARSIZE  = AXSIZE;
    assign ARBURST = BURST_INCR;

endmodule

// File: tb/tb_axi_burst_manager.sv
// tb_axi_burst_manager: directed self-checking bench for axi_burst_manager
// (DATA_W=32, ADDR_W=32, MAX_BEATS=16). The bench plays both the local client
// and the AXI subordinate; inputs change and outputs are sampled on the
// falling clock edge.
module tb_axi_burst_manager;

    logic        ACLK;
    logic        ARESETn;
    logic        wr_req_valid, wr_req_ready;
    logic [31:0] wr_addr;
    logic [7:0]  wr_len;
    logic        wr_data_valid, wr_data_ready;
    logic [31:0] wr_data;
    logic        wr_done;
    logic [1:0]  wr_resp;
    logic        rd_req_valid, rd_req_ready;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_last;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;

    int n_checks = 0;
    int n_errors = 0;

    axi_burst_manager #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .MAX_BEATS (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_addr       (wr_addr),
        .wr_len        (wr_len),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .wr_data       (wr_data),
        .wr_done       (wr_done),
        .wr_resp       (wr_resp),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_resp       (rd_resp),
        .rd_last       (rd_last),
        .AWADDR        (AWADDR),
        .AWLEN         (AWLEN),
        .AWSIZE        (AWSIZE),
        .AWBURST       (AWBURST),
        .AWVALID       (AWVALID),
        .AWREADY       (AWREADY),
        .WDATA         (WDATA),
        .WSTRB         (WSTRB),
        .WLAST         (WLAST),
        .WVALID        (WVALID),
        .WREADY        (WREADY),
        .BRESP         (BRESP),
        .BVALID        (BVALID),
        .BREADY        (BREADY),
        .ARADDR        (ARADDR),
        .ARLEN         (ARLEN),
        .ARSIZE        (ARSIZE),
        .ARBURST       (ARBURST),
        .ARVALID       (ARVALID),
        .ARREADY       (ARREADY),
        .RDATA         (RDATA),
        .RRESP         (RRESP),
        .RLAST         (RLAST),
        .RVALID        (RVALID),
        .RREADY        (RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Client write command plus subordinate AW/W/B responses.
    task automatic run_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                             input int aw_delay, input logic [1:0] bresp, input logic [31:0] dbase);
        @(negedge ACLK);
        wr_req_valid = 1'b1;
        wr_addr      = addr;
        wr_len       = len;
        #1 check({tag, "_req_ready"}, wr_req_ready, 1);
        @(posedge ACLK);
        @(negedge ACLK);
        wr_req_valid = 1'b0;
        #1;
        check({tag, "_awvalid"}, AWVALID, 1);
        check({tag, "_awaddr"}, AWADDR, addr);
        check({tag, "_awlen"}, AWLEN, len);
        check({tag, "_awsize"}, AWSIZE, 2);
        check({tag, "_awburst"}, AWBURST, 1);
        check({tag, "_req_busy"}, wr_req_ready, 0);
        repeat (aw_delay) begin
            @(posedge ACLK);
            @(negedge ACLK);
            #1 check({tag, "_aw_hold"}, AWVALID, 1);
        end
        AWREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        AWREADY = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wr_data_valid = 1'b1;
            WREADY        = 1'b1;
            wr_data       = dbase + 32'(i);
            #1;
            check({tag, "_wvalid"}, WVALID, 1);
            check({tag, "_wdata"}, WDATA, dbase + 32'(i));
            check({tag, "_wlast"}, WLAST, (i == int'(len)) ? 1 : 0);
            check({tag, "_wstrb"}, WSTRB, 4'hF);
            check({tag, "_wr_data_ready"}, wr_data_ready, 1);
            @(posedge ACLK);
            @(negedge ACLK);
        end
        wr_data_valid = 1'b0;
        WREADY        = 1'b0;
        #1;
        check({tag, "_bready"}, BREADY, 1);
        check({tag, "_w_idle"}, WVALID, 0);
        check({tag, "_no_early_done"}, wr_done, 0);
        BVALID = 1'b1;
        BRESP  = bresp;
        @(posedge ACLK);
        @(negedge ACLK);
        BVALID = 1'b0;
        BRESP  = 2'b00;
        #1;
        check({tag, "_done"}, wr_done, 1);
        check({tag, "_resp"}, wr_resp, bresp);
        check({tag, "_req_ready_back"}, wr_req_ready, 1);
        @(negedge ACLK);
        #1 check({tag, "_done_pulse"}, wr_done, 0);
    endtask

    // Client read command plus subordinate AR/R responses. rlast_at < 0 means
    // the subordinate ends the burst correctly on beat len.
    task automatic run_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input bit throttle, input int rlast_at);
        int  last_idx;
        int  b;
        int  cyc;
        bit  done;
        logic [1:0] exp_resp;
        last_idx = (rlast_at < 0) ? int'(len) : rlast_at;
        b        = 0;
        done     = 1'b0;
        cyc      = 0;
        @(negedge ACLK);
        rd_req_valid = 1'b1;
        rd_addr      = addr;
        rd_len       = len;
        #1 check({tag, "_req_ready"}, rd_req_ready, 1);
        @(posedge ACLK);
        @(negedge ACLK);
        rd_req_valid = 1'b0;
        #1;
        check({tag, "_arvalid"}, ARVALID, 1);
        check({tag, "_araddr"}, ARADDR, addr);
        check({tag, "_arlen"}, ARLEN, len);
        check({tag, "_req_busy"}, rd_req_ready, 0);
        ARREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        ARREADY = 1'b0;
        while (!done && cyc < 4 * (int'(len) + 1) + 8) begin
            RVALID   = 1'b1;
            RDATA    = 32'hA500_0000 + 32'(b);
            RLAST    = (b == last_idx);
            RRESP    = 2'b00;
            rd_ready = throttle ? (cyc % 2 == 0) : 1'b1;
            #1;
            check({tag, "_rd_valid"}, rd_valid, 1);
            check({tag, "_rready"}, RREADY, rd_ready);
            if (rd_ready) begin
                exp_resp = (b == last_idx && last_idx != int'(len)) ? 2'b10 : 2'b00;
                check({tag, "_rd_data"}, rd_data, 32'hA500_0000 + 32'(b));
                check({tag, "_rd_last"}, rd_last, (b == last_idx) ? 1 : 0);
                check({tag, "_rd_resp"}, rd_resp, exp_resp);
                if (b == last_idx) done = 1'b1;
                b++;
            end
            @(posedge ACLK);
            @(negedge ACLK);
            cyc++;
        end
        RVALID   = 1'b0;
        RLAST    = 1'b0;
        rd_ready = 1'b0;
        #1;
        check({tag, "_completed"}, done, 1);
        check({tag, "_beats"}, b, last_idx + 1);
        if (!throttle) check({tag, "_data_cycles"}, cyc, last_idx + 1);
        check({tag, "_req_ready_back"}, rd_req_ready, 1);
        check({tag, "_rd_valid_off"}, rd_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn       = 1'b0;
        wr_req_valid  = 1'b0;  wr_addr = '0;  wr_len = '0;
        wr_data_valid = 1'b0;  wr_data = '0;
        rd_req_valid  = 1'b0;  rd_addr = '0;  rd_len = '0;  rd_ready = 1'b0;
        AWREADY = 1'b0;  WREADY = 1'b0;  BVALID = 1'b0;  BRESP = 2'b00;
        ARREADY = 1'b0;  RVALID = 1'b0;  RDATA = '0;  RRESP = 2'b00;  RLAST = 1'b0;

        // Reset state
        repeat (3) @(negedge ACLK);
        #1;
        check("rst_awvalid", AWVALID, 0);
        check("rst_wvalid", WVALID, 0);
        check("rst_bready", BREADY, 0);
        check("rst_arvalid", ARVALID, 0);
        check("rst_rready", RREADY, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wlast", WLAST, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_wr_resp", wr_resp, 0);
        check("rst_awaddr", AWADDR, 0);
        check("rst_arlen", ARLEN, 0);
        check("rst_wr_req_ready", wr_req_ready, 1);
        check("rst_rd_req_ready", rd_req_ready, 1);
        @(negedge ACLK);
        ARESETn = 1'b1;

        // Basic 4-beat write
        run_write("wr100", 32'h0000_0100, 8'd3, 0, 2'b00, 32'h1111_0000);

        // 8-beat read with client stalling every other cycle
        run_read("rd200", 32'h0000_0200, 8'd7, 1'b1, -1);

        // Burst ending exactly on a 4 KB boundary is legal; BRESP propagates
        run_write("wrff0", 32'h0000_0FF0, 8'd3, 0, 2'b10, 32'h2222_0000);

        // Crossing 4 KB: local DECERR, client data not consumed
        @(negedge ACLK);
        wr_req_valid  = 1'b1;
        wr_addr       = 32'h0000_0FF8;
        wr_len        = 8'd3;
        wr_data_valid = 1'b1;
        wr_data       = 32'hDEAD_BEEF;
        @(posedge ACLK);
        @(negedge ACLK);
        wr_req_valid = 1'b0;
        #1;
        check("wr4k_done", wr_done, 1);
        check("wr4k_resp", wr_resp, 2'b11);
        check("wr4k_awvalid", AWVALID, 0);
        check("wr4k_data_ready", wr_data_ready, 0);
        check("wr4k_wvalid", WVALID, 0);
        @(negedge ACLK);
        #1;
        check("wr4k_done_pulse", wr_done, 0);
        check("wr4k_awvalid_after", AWVALID, 0);
        wr_data_valid = 1'b0;

        // Over-length read (17 beats): single DECERR beat, no AR traffic
        @(negedge ACLK);
        rd_req_valid = 1'b1;
        rd_addr      = 32'h0000_1000;
        rd_len       = 8'd16;
        rd_ready     = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        rd_req_valid = 1'b0;
        #1;
        check("rdlen_valid", rd_valid, 1);
        check("rdlen_last", rd_last, 1);
        check("rdlen_resp", rd_resp, 2'b11);
        check("rdlen_data", rd_data, 0);
        check("rdlen_arvalid", ARVALID, 0);
        @(negedge ACLK);
        #1 check("rdlen_hold", rd_valid, 1);
        rd_ready = 1'b1;
        @(negedge ACLK);
        rd_ready = 1'b0;
        #1;
        check("rdlen_valid_off", rd_valid, 0);
        check("rdlen_req_ready", rd_req_ready, 1);

        // Concurrent 16-beat write (AW stalled 5 cycles) and 16-beat read
        fork
            run_write("cwr", 32'h0000_0400, 8'd15, 5, 2'b00, 32'h3333_0000);
            run_read("crd", 32'h0000_0800, 8'd15, 1'b0, -1);
        join

        // Early RLAST on the second beat of a 4-beat read
        run_read("rdearly", 32'h0000_0300, 8'd3, 1'b0, 1);

        // Reset asserted during the second W beat
        @(negedge ACLK);
        wr_req_valid = 1'b1;
        wr_addr      = 32'h0000_0500;
        wr_len       = 8'd3;
        @(posedge ACLK);
        @(negedge ACLK);
        wr_req_valid = 1'b0;
        AWREADY      = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        AWREADY       = 1'b0;
        wr_data_valid = 1'b1;
        WREADY        = 1'b1;
        wr_data       = 32'h4444_0000;
        @(posedge ACLK);
        @(negedge ACLK);
        wr_data = 32'h4444_0001;
        #1 check("mrst_wvalid_before", WVALID, 1);
        #1 ARESETn = 1'b0;
        #1;
        check("mrst_awvalid", AWVALID, 0);
        check("mrst_wvalid", WVALID, 0);
        check("mrst_bready", BREADY, 0);
        check("mrst_arvalid", ARVALID, 0);
        check("mrst_wlast", WLAST, 0);
        wr_data_valid = 1'b0;
        WREADY        = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("mrst_req_ready", wr_req_ready, 1);
        check("mrst_no_done", wr_done, 0);
        @(negedge ACLK);
        #1 check("mrst_no_done_later", wr_done, 0);
        run_write("wrpost", 32'h0000_0600, 8'd1, 0, 2'b00, 32'h5555_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
